// File: rtl/memoria_datos_if.sv
// Bus bundle for the word-addressed data memory: write/read enables, address,
// write data and combinational read data.
interface memoria_datos_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic                  EscrMem;
   logic [ADDR_WIDTH-1:0] Direc;
   logic [DATA_WIDTH-1:0] Datain;
   logic                  LeerMem;
   logic [DATA_WIDTH-1:0] Dataout;

   modport master (
      output EscrMem, Direc, Datain, LeerMem,
      input  Dataout
   );

   modport slave (
      input  EscrMem, Direc, Datain, LeerMem,
      output Dataout
   );
endinterface

// File: rtl/memoria_datos.sv
// Data memory: DEPTH words, synchronous write, combinational read, whole
// array cleared asynchronously by reset.
module memoria_datos #(
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_WIDTH = 8,
   parameter int unsigned DEPTH      = 2**ADDR_WIDTH
) (
   input logic             clk,
   input logic             reset,
   memoria_datos_if.slave  bus
);

   localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
   logic                  in_range;

   // Addresses past the last word are neither written nor read; no wrap.
   assign in_range = ({1'b0, bus.Direc} < LIMIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem <= '{default: '0};
      end else if (bus.EscrMem && in_range) begin
         mem[bus.Direc] <= bus.Datain;
      end
   end

   always_comb begin
      bus.Dataout = '0;
      if (!reset && bus.LeerMem && in_range) begin
         bus.Dataout = mem[bus.Direc];
      end
   end

endmodule

// File: tb/tb_memoria_datos.sv
// Self-checking bench for memoria_datos: a reference array supplies expected
// read data, queued at stimulus time and popped when Dataout is sampled.
module tb_memoria_datos;

   localparam int DW = 32;
   localparam int AW = 8;

   logic clk;
   logic reset;

   memoria_datos_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   memoria_datos #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] model [256];
   logic [DW-1:0] sb [$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 256; i++) model[i] = '0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      bus.EscrMem = 1'b1;
      bus.Direc   = a;
      bus.Datain  = d;
      @(posedge clk);
      #1;
      bus.EscrMem = 1'b0;
      model[a] = d;
   endtask

   // Expected value is queued as the read is driven, compared once settled.
   task automatic rd(input string tag, input logic [AW-1:0] a, input logic en);
      bus.LeerMem = en;
      bus.Direc   = a;
      sb.push_back(en ? model[a] : '0);
      #1;
      check(tag, bus.Dataout, sb.pop_front());
   endtask

   task automatic expect_now(input string tag, input logic [DW-1:0] exp);
      sb.push_back(exp);
      #1;
      check(tag, bus.Dataout, sb.pop_front());
   endtask

   initial begin
      logic [AW-1:0] ra;
      logic [DW-1:0] rdat;

      clear_model();
      reset       = 1'b1;
      bus.EscrMem = 1'b0;
      bus.LeerMem = 1'b1;
      bus.Direc   = 8'h10;
      bus.Datain  = 32'hA5A5A5A5;

      // Reads zero and writes are blocked while reset is held across an edge.
      #2;
      expect_now("rst_read", '0);
      bus.EscrMem = 1'b1;
      @(posedge clk);
      #1;
      expect_now("rst_read_after_edge", '0);
      bus.EscrMem = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      rd("rst_blocked_wr", 8'h10, 1'b1);

      rd("post_rst_00", 8'h00, 1'b1);
      rd("post_rst_01", 8'h01, 1'b1);
      rd("post_rst_ff", 8'hFF, 1'b1);

      wr(8'h00, 32'h00000060);
      rd("wr00_rd00", 8'h00, 1'b1);
      rd("wr00_rd01", 8'h01, 1'b1);

      wr(8'h02, 32'h0000000C);
      @(negedge clk);
      bus.EscrMem = 1'b0;
      bus.Direc   = 8'h03;
      bus.Datain  = 32'h000000C0;
      @(posedge clk);
      #1;
      rd("noen_rd03", 8'h03, 1'b1);
      rd("noen_rd02", 8'h02, 1'b1);

      // Same-address read during write: old word before the edge, new after.
      @(negedge clk);
      bus.LeerMem = 1'b1;
      bus.EscrMem = 1'b1;
      bus.Direc   = 8'h05;
      bus.Datain  = 32'hDEADBEEF;
      expect_now("rw05_before", 32'h00000000);
      @(posedge clk);
      #1;
      bus.EscrMem = 1'b0;
      model[8'h05] = 32'hDEADBEEF;
      expect_now("rw05_after", 32'hDEADBEEF);
      rd("rw05_leer0", 8'h05, 1'b0);

      wr(8'hFF, 32'h13579BDF);
      rd("top_word_ff", 8'hFF, 1'b1);
      rd("no_wrap_00", 8'h00, 1'b1);
      rd("leer0_ff", 8'hFF, 1'b0);

      for (int i = 0; i < 40; i++) begin
         ra   = AW'($urandom_range(0, 255));
         rdat = $urandom;
         if ($urandom_range(0, 1) == 1) wr(ra, rdat);
         rd("rand_rd", ra, 1'b1);
      end

      // Write interrupted by a mid-cycle asynchronous reset.
      wr(8'hFF, 32'h12345678);
      rd("pre_abort_ff", 8'hFF, 1'b1);
      @(negedge clk);
      bus.EscrMem = 1'b1;
      bus.Direc   = 8'hFF;
      bus.Datain  = 32'hCAFEF00D;
      bus.LeerMem = 1'b1;
      #2;
      reset = 1'b1;
      clear_model();
      expect_now("abort_rst_high", '0);
      @(posedge clk);
      #1;
      expect_now("abort_rst_edge", '0);
      bus.EscrMem = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      rd("abort_rd_ff", 8'hFF, 1'b1);
      rd("abort_rd_05", 8'h05, 1'b1);
      rd("abort_rd_02", 8'h02, 1'b1);

      wr(8'h07, 32'h0BADC0DE);
      rd("first_wr_after_rst", 8'h07, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
